// File: rtl/debounce_pkg.sv
// Shared constants for the debouncer: FSM state encoding and parameter defaults.
// Also imported by the simulation bench so both sides agree on the defaults.
package debounce_pkg;

  localparam logic ST_STABLE  = 1'b0;
  localparam logic ST_QUALIFY = 1'b1;

  localparam int   DEF_SYNC_STAGES   = 2;
  localparam int   DEF_STABLE_CYCLES = 8;
  localparam logic DEF_INIT_LEVEL    = 1'b0;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit.
// All stages reset to INIT_LEVEL so no spurious edge appears when reset releases.
module sync_ff
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic INIT_LEVEL  = DEF_INIT_LEVEL
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_depth
      $error("sync_ff: SYNC_STAGES must be at least 2");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] stage_q;
  logic [SYNC_STAGES-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[SYNC_STAGES-2:0], d};
  end

  // NOTE: non-blocking assignment keeps every stage sampling the pre-edge value of its neighbour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= {SYNC_STAGES{INIT_LEVEL}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/debouncer.sv
// Synchronizes a raw level and commits a change only after STABLE_CYCLES consecutive
// differing samples; emits registered rise/fall pulses and a busy flag.
module debouncer
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter logic INIT_LEVEL    = DEF_INIT_LEVEL
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic sig_out,
  output logic rise,
  output logic fall,
  output logic busy
);

  generate
    if (STABLE_CYCLES < 2) begin : g_bad_count
      $error("debouncer: STABLE_CYCLES must be at least 2");
    end
  endgenerate

  localparam int               CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s;
  logic             state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             sig_out_q, sig_out_d;
  logic             rise_q,    rise_d;
  logic             fall_q,    fall_d;
  logic             busy_q,    busy_d;

  sync_ff #(
    .SYNC_STAGES (SYNC_STAGES),
    .INIT_LEVEL  (INIT_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sig_in),
    .q   (s)
  );

  // NOTE: every variable gets a default before any branch, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sig_out_d = sig_out_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;

    if (state_q == ST_STABLE) begin
      if (s != sig_out_q) begin
        state_d = ST_QUALIFY;
        cnt_d   = CNT_ONE;
      end
    end else begin
      if (s == sig_out_q) begin
        // Run broken before reaching the threshold: treat it as a glitch.
        state_d = ST_STABLE;
        cnt_d   = '0;
      end else if (cnt_q == CNT_LAST) begin
        state_d   = ST_STABLE;
        cnt_d     = '0;
        sig_out_d = s;
        rise_d    = s;
        fall_d    = ~s;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    busy_d = (state_d == ST_QUALIFY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_STABLE;
      cnt_q     <= '0;
      sig_out_q <= INIT_LEVEL;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sig_out_q <= sig_out_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      busy_q    <= busy_d;
    end
  end

  assign sig_out = sig_out_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign busy    = busy_q;

endmodule
